// File: rtl/rs_busy_tracker.sv
// Reservation-station busy bits with per-group free counters and a sticky protocol-error flag.
// Dispatch sets a station's busy bit, the CDB broadcast of its tag clears it, and flush clears all of them.
module rs_busy_tracker #(
    parameter int unsigned NUM_RS     = 6,
    parameter int unsigned NUM_ALU_RS = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            alloc_valid_i,
    input  logic [$clog2(NUM_RS)-1:0]       alloc_addr_i,
    input  logic                            cdb_valid_i,
    input  logic [$clog2(NUM_RS)-1:0]       cdb_addr_i,
    input  logic                            flush_i,
    output logic [NUM_RS-1:0]               busy_bus_o,
    output logic [$clog2(NUM_RS+1)-1:0]     alu_free_cnt_o,
    output logic [$clog2(NUM_RS+1)-1:0]     shift_free_cnt_o,
    output logic                            alu_full_o,
    output logic                            shift_full_o,
    output logic                            err_o
);

    localparam int unsigned AW = $clog2(NUM_RS);
    localparam int unsigned CW = $clog2(NUM_RS + 1);
    localparam logic [CW-1:0] ALU_RST   = CW'(NUM_ALU_RS);
    localparam logic [CW-1:0] SHIFT_RST = CW'(NUM_RS - NUM_ALU_RS);

    logic [NUM_RS-1:0] busy_q, busy_n, busy_rel;
    logic [CW-1:0]     alu_cnt_q, alu_cnt_n;
    logic [CW-1:0]     shift_cnt_q, shift_cnt_n;
    logic              alu_full_q, alu_full_n;
    logic              shift_full_q, shift_full_n;
    logic              err_q, err_n;

    logic rel_in_range, rel_ok, rel_err, rel_alu;
    logic alc_in_range, alc_ok, alc_err, alc_alu;

    // Legality of each operation; release is resolved first so a same-cycle re-allocate is legal.
    always_comb begin
        rel_in_range = 32'(cdb_addr_i) < NUM_RS;
        rel_ok       = cdb_valid_i && rel_in_range && busy_q[cdb_addr_i];
        rel_err      = cdb_valid_i && !rel_ok;
        rel_alu      = 32'(cdb_addr_i) < NUM_ALU_RS;

        busy_rel = busy_q;
        if (rel_ok) begin
            busy_rel[cdb_addr_i] = 1'b0;
        end

        alc_in_range = 32'(alloc_addr_i) < NUM_RS;
        alc_ok       = alloc_valid_i && alc_in_range && !busy_rel[alloc_addr_i];
        alc_err      = alloc_valid_i && !alc_ok;
        alc_alu      = 32'(alloc_addr_i) < NUM_ALU_RS;
    end

    // Next state: flush dominates, otherwise apply the legal release and allocate.
    always_comb begin
        busy_n      = busy_rel;
        alu_cnt_n   = alu_cnt_q;
        shift_cnt_n = shift_cnt_q;
        err_n       = err_q;

        if (flush_i) begin
            busy_n      = '0;
            alu_cnt_n   = ALU_RST;
            shift_cnt_n = SHIFT_RST;
        end else begin
            if (alc_ok) begin
                busy_n[alloc_addr_i] = 1'b1;
            end
            alu_cnt_n   = alu_cnt_q
                        + CW'(rel_ok && rel_alu)
                        - CW'(alc_ok && alc_alu);
            shift_cnt_n = shift_cnt_q
                        + CW'(rel_ok && !rel_alu)
                        - CW'(alc_ok && !alc_alu);
            err_n       = err_q || rel_err || alc_err;
        end

        alu_full_n   = (alu_cnt_n == '0);
        shift_full_n = (shift_cnt_n == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q       <= '0;
            alu_cnt_q    <= ALU_RST;
            shift_cnt_q  <= SHIFT_RST;
            alu_full_q   <= 1'b0;
            shift_full_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            busy_q       <= busy_n;
            alu_cnt_q    <= alu_cnt_n;
            shift_cnt_q  <= shift_cnt_n;
            alu_full_q   <= alu_full_n;
            shift_full_q <= shift_full_n;
            err_q        <= err_n;
        end
    end

    assign busy_bus_o       = busy_q;
    assign alu_free_cnt_o   = alu_cnt_q;
    assign shift_free_cnt_o = shift_cnt_q;
    assign alu_full_o       = alu_full_q;
    assign shift_full_o     = shift_full_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_rs_busy_tracker.sv
// Table-driven bench for rs_busy_tracker; expected outputs queue at drive time and are checked after the edge.
module tb_rs_busy_tracker;

    localparam int unsigned NUM_RS     = 6;
    localparam int unsigned NUM_ALU_RS = 3;
    localparam int unsigned AW         = $clog2(NUM_RS);
    localparam int unsigned CW         = $clog2(NUM_RS + 1);
    localparam int unsigned NVEC       = 25;

    typedef struct {
        logic [NUM_RS-1:0] busy;
        logic [CW-1:0]     alu;
        logic [CW-1:0]     sh;
        logic              af;
        logic              sf;
        logic              err;
    } exp_t;

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic          cv;
        logic [AW-1:0] ca;
        logic          fl;
        exp_t          e;
    } vec_t;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              alloc_valid_i;
    logic [AW-1:0]     alloc_addr_i;
    logic              cdb_valid_i;
    logic [AW-1:0]     cdb_addr_i;
    logic              flush_i;
    logic [NUM_RS-1:0] busy_bus_o;
    logic [CW-1:0]     alu_free_cnt_o;
    logic [CW-1:0]     shift_free_cnt_o;
    logic              alu_full_o;
    logic              shift_full_o;
    logic              err_o;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    vec_t tbl[NVEC];

    rs_busy_tracker #(.NUM_RS(NUM_RS), .NUM_ALU_RS(NUM_ALU_RS)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alloc_valid_i(alloc_valid_i), .alloc_addr_i(alloc_addr_i),
        .cdb_valid_i(cdb_valid_i), .cdb_addr_i(cdb_addr_i), .flush_i(flush_i),
        .busy_bus_o(busy_bus_o), .alu_free_cnt_o(alu_free_cnt_o),
        .shift_free_cnt_o(shift_free_cnt_o), .alu_full_o(alu_full_o),
        .shift_full_o(shift_full_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic exp_t mke(input int busy, input int alu, input int sh, input bit err);
        exp_t e;
        e.busy = NUM_RS'(busy);
        e.alu  = CW'(alu);
        e.sh   = CW'(sh);
        e.af   = (alu == 0);
        e.sf   = (sh == 0);
        e.err  = err;
        return e;
    endfunction

    function automatic vec_t mkv(input bit av, input int aa, input bit cv, input int ca,
                                 input bit fl, input exp_t e);
        vec_t v;
        v.av = av; v.aa = AW'(aa); v.cv = cv; v.ca = AW'(ca); v.fl = fl; v.e = e;
        return v;
    endfunction

    task automatic check(input string name, input exp_t e);
        n_vec++;
        if (busy_bus_o !== e.busy || alu_free_cnt_o !== e.alu || shift_free_cnt_o !== e.sh ||
            alu_full_o !== e.af || shift_full_o !== e.sf || err_o !== e.err) begin
            n_bad++;
            $display("FAIL %s: got busy=%b alu=%0d sh=%0d af=%b sf=%b err=%b, want busy=%b alu=%0d sh=%0d af=%b sf=%b err=%b",
                     name, busy_bus_o, alu_free_cnt_o, shift_free_cnt_o, alu_full_o, shift_full_o, err_o,
                     e.busy, e.alu, e.sh, e.af, e.sf, e.err);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, and check it just after the edge.
    task automatic apply(input string name, input vec_t v);
        exp_t e;
        @(negedge clk_i);
        alloc_valid_i = v.av; alloc_addr_i = v.aa;
        cdb_valid_i   = v.cv; cdb_addr_i   = v.ca;
        flush_i       = v.fl;
        sb_q.push_back(v.e);
        @(posedge clk_i);
        #1;
        alloc_valid_i = 1'b0; cdb_valid_i = 1'b0; flush_i = 1'b0;
        if (sb_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL %s: scoreboard empty, want 1 entry", name);
        end else begin
            e = sb_q.pop_front();
            check(name, e);
        end
    endtask

    initial begin
        // alloc 0..2, fill SHIFT, release 5..0
        tbl[0]  = mkv(1, 0, 0, 0, 0, mke(6'b000001, 2, 3, 0));
        tbl[1]  = mkv(1, 1, 0, 0, 0, mke(6'b000011, 1, 3, 0));
        tbl[2]  = mkv(1, 2, 0, 0, 0, mke(6'b000111, 0, 3, 0));
        tbl[3]  = mkv(1, 3, 0, 0, 0, mke(6'b001111, 0, 2, 0));
        tbl[4]  = mkv(1, 4, 0, 0, 0, mke(6'b011111, 0, 1, 0));
        tbl[5]  = mkv(1, 5, 0, 0, 0, mke(6'b111111, 0, 0, 0));
        tbl[6]  = mkv(0, 0, 1, 5, 0, mke(6'b011111, 0, 1, 0));
        tbl[7]  = mkv(0, 0, 1, 4, 0, mke(6'b001111, 0, 2, 0));
        tbl[8]  = mkv(0, 0, 1, 3, 0, mke(6'b000111, 0, 3, 0));
        tbl[9]  = mkv(0, 0, 1, 2, 0, mke(6'b000011, 1, 3, 0));
        tbl[10] = mkv(0, 0, 1, 1, 0, mke(6'b000001, 2, 3, 0));
        tbl[11] = mkv(0, 0, 1, 0, 0, mke(6'b000000, 3, 3, 0));
        // same-address and cross-address release+allocate
        tbl[12] = mkv(1, 4, 0, 0, 0, mke(6'b010000, 3, 2, 0));
        tbl[13] = mkv(1, 4, 1, 4, 0, mke(6'b010000, 3, 2, 0));
        tbl[14] = mkv(1, 1, 0, 0, 0, mke(6'b010010, 2, 2, 0));
        tbl[15] = mkv(1, 0, 1, 1, 0, mke(6'b010001, 2, 2, 0));
        tbl[16] = mkv(1, 1, 0, 0, 0, mke(6'b010011, 1, 2, 0));
        // protocol errors: busy alloc, free release, out-of-range alloc, bad release beside good alloc
        tbl[17] = mkv(1, 1, 0, 0, 0, mke(6'b010011, 1, 2, 1));
        tbl[18] = mkv(0, 0, 1, 3, 0, mke(6'b010011, 1, 2, 1));
        tbl[19] = mkv(1, 6, 0, 0, 0, mke(6'b010011, 1, 2, 1));
        tbl[20] = mkv(1, 2, 1, 7, 0, mke(6'b010111, 0, 2, 1));
        // build 101101, then flush with competing ops
        tbl[21] = mkv(1, 3, 1, 4, 0, mke(6'b001111, 0, 2, 1));
        tbl[22] = mkv(1, 5, 1, 1, 0, mke(6'b101101, 1, 1, 1));
        tbl[23] = mkv(1, 1, 0, 0, 1, mke(6'b000000, 3, 3, 1));
        tbl[24] = mkv(0, 0, 1, 0, 1, mke(6'b000000, 3, 3, 1));

        rst_ni = 1'b0;
        alloc_valid_i = 1'b0; alloc_addr_i = '0;
        cdb_valid_i = 1'b0; cdb_addr_i = '0; flush_i = 1'b0;
        #12;
        check("reset_state", mke(0, 3, 3, 0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Refill every station, then pull reset between edges.
        for (int i = 0; i < int'(NUM_RS); i++) begin
            apply($sformatf("fill%0d", i),
                  mkv(1, i, 0, 0, 0,
                      mke((1 << (i + 1)) - 1, (i < 3) ? 2 - i : 0, (i < 3) ? 3 : 5 - i, 1)));
        end
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check("async_reset", mke(0, 3, 3, 0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        apply("post_reset_alloc", mkv(1, 2, 0, 0, 0, mke(6'b000100, 2, 3, 0)));

        if (sb_q.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
